// File: rtl/riscv_pkg.sv
// Shared types and helpers for the execute-stage RV32M multiply/divide unit.
// Divide special cases are resolved from the operands alone, so they live here as pure functions.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b11
    } fwd_sel_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } md_state_e;

    // The reserved select 2'b10 falls through to the register-file operand.
    function automatic logic [XLEN-1:0] fwdMux(input logic [1:0] sel,
                                               input logic [XLEN-1:0] rf,
                                               input logic [XLEN-1:0] w,
                                               input logic [XLEN-1:0] m);
        logic [XLEN-1:0] res;
        res = rf;
        if (sel == FWD_W) res = w;
        else if (sel == FWD_M) res = m;
        return res;
    endfunction

    function automatic logic isSpecialDiv(input logic [2:0] f3,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
        logic divByZero;
        logic overflow;
        divByZero = (b == '0);
        overflow  = !f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        return f3[2] && (divByZero || overflow);
    endfunction

    function automatic logic [XLEN-1:0] specialDivResult(input logic [2:0] f3,
                                                         input logic [XLEN-1:0] a,
                                                         input logic [XLEN-1:0] b);
        logic [XLEN-1:0] res;
        if (b == '0) res = f3[1] ? a : '1;
        else         res = f3[1] ? '0 : 32'h8000_0000;
        return res;
    endfunction

endpackage

// File: rtl/md_divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, done pulses the cycle after the last step.
module md_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] quotient_o,
    output logic [W-1:0] remainder_o
);

    localparam int CW = $clog2(W);

    logic [W-1:0]  quot_q;
    logic [W-1:0]  rem_q;
    logic [W-1:0]  divisor_q;
    logic [CW-1:0] count_q;
    logic          busy_q;
    logic          done_q;

    logic [W:0]    trial;
    logic          fits;
    logic [W-1:0]  remNext;

    // The dividend is shifted out of the quotient register while quotient bits shift in.
    assign trial   = {rem_q, quot_q[W-1]};
    assign fits    = (trial >= {1'b0, divisor_q});
    assign remNext = fits ? W'(trial - {1'b0, divisor_q}) : trial[W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                busy_q <= 1'b0;
            end else if (start_i) begin
                quot_q    <= dividend_i;
                rem_q     <= '0;
                divisor_q <= divisor_i;
                count_q   <= CW'(W - 1);
                busy_q    <= 1'b1;
            end else if (busy_q) begin
                quot_q <= {quot_q[W-2:0], fits};
                rem_q  <= remNext;
                if (count_q == '0) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage RV32M unit: forwards operands, runs MUL/DIV over several cycles and stalls the pipe meanwhile.
// Divide special cases reuse the single-cycle MUL slot so they finish with the same latency as a multiply.
module ex_muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_E,
    input  logic [2:0]      funct3_E,
    input  logic            flush_E,
    input  logic [1:0]      forwardAE,
    input  logic [1:0]      forwardBE,
    input  logic [XLEN-1:0] rd1_E,
    input  logic [XLEN-1:0] rd2_E,
    input  logic [XLEN-1:0] alu_result_M,
    input  logic [XLEN-1:0] result_W,
    output logic            md_stall,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);

    md_state_e       state_q;
    logic [XLEN-1:0] opA_q;
    logic [XLEN-1:0] opB_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] result_q;

    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic            issue;
    logic            issueSpecial;
    logic            divStart;
    logic            issueSigned;
    logic [XLEN-1:0] divDividend;
    logic [XLEN-1:0] divDivisor;

    logic            divBusy;
    logic            divDone;
    logic [XLEN-1:0] divQuot;
    logic [XLEN-1:0] divRem;

    assign opA = fwdMux(forwardAE, rd1_E, result_W, alu_result_M);
    assign opB = fwdMux(forwardBE, rd2_E, result_W, alu_result_M);

    assign issue        = (state_q == IDLE) && start_E && !flush_E;
    assign issueSpecial = isSpecialDiv(funct3_E, opA, opB);
    assign divStart     = issue && funct3_E[2] && !issueSpecial;
    assign issueSigned  = !funct3_E[0];
    assign divDividend  = (issueSigned && opA[XLEN-1]) ? -opA : opA;
    assign divDivisor   = (issueSigned && opB[XLEN-1]) ? -opB : opB;

    md_divider #(.W(XLEN)) u_divider (
        .clk         (clk),
        .rst         (rst),
        .start_i     (divStart),
        .abort_i     (flush_E),
        .dividend_i  (divDividend),
        .divisor_i   (divDivisor),
        .busy_o      (divBusy),
        .done_o      (divDone),
        .quotient_o  (divQuot),
        .remainder_o (divRem)
    );

    // Operands are extended to 64 bits so a plain unsigned multiply yields the correct low 64 product bits.
    md_op_e          op_q;
    logic            aSigned;
    logic            bSigned;
    logic [63:0]     a64;
    logic [63:0]     b64;
    logic [63:0]     product;
    logic [XLEN-1:0] mulResult;
    logic [XLEN-1:0] mulSlotResult;

    assign op_q      = md_op_e'(funct3_q);
    assign aSigned   = (op_q == OP_MULH) || (op_q == OP_MULHSU);
    assign bSigned   = (op_q == OP_MULH);
    assign a64       = {{32{aSigned & opA_q[XLEN-1]}}, opA_q};
    assign b64       = {{32{bSigned & opB_q[XLEN-1]}}, opB_q};
    assign product   = a64 * b64;
    assign mulResult = (op_q == OP_MUL) ? product[31:0] : product[63:32];
    assign mulSlotResult = funct3_q[2] ? specialDivResult(funct3_q, opA_q, opB_q) : mulResult;

    logic            negQuot;
    logic            negRem;
    logic [XLEN-1:0] divResult;

    assign negQuot   = !funct3_q[0] && (opA_q[XLEN-1] ^ opB_q[XLEN-1]);
    assign negRem    = !funct3_q[0] && opA_q[XLEN-1];
    assign divResult = funct3_q[1] ? (negRem ? -divRem : divRem)
                                   : (negQuot ? -divQuot : divQuot);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            opA_q    <= '0;
            opB_q    <= '0;
            funct3_q <= '0;
            result_q <= '0;
        end else if (flush_E) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_E) begin
                        opA_q    <= opA;
                        opB_q    <= opB;
                        funct3_q <= funct3_E;
                        state_q  <= (funct3_E[2] && !issueSpecial) ? DIV : MUL;
                    end
                end
                MUL: begin
                    result_q <= mulSlotResult;
                    state_q  <= DONE;
                end
                DIV: begin
                    if (divDone) begin
                        result_q <= divResult;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign md_stall  = !flush_E && (issue || (state_q == MUL) || (state_q == DIV) || divBusy);
    assign md_done   = (state_q == DONE) && !flush_E;
    assign md_result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: issuing pushes the expected result and done cycle, a monitor pops on md_done.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_E = 1'b0;
    logic [2:0]  funct3_E = 3'b000;
    logic        flush_E = 1'b0;
    logic [1:0]  forwardAE = 2'b00;
    logic [1:0]  forwardBE = 2'b00;
    logic [31:0] rd1_E = '0;
    logic [31:0] rd2_E = '0;
    logic [31:0] alu_result_M = '0;
    logic [31:0] result_W = '0;
    logic        md_stall;
    logic        md_done;
    logic [31:0] md_result;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_E      (start_E),
        .funct3_E     (funct3_E),
        .flush_E      (flush_E),
        .forwardAE    (forwardAE),
        .forwardBE    (forwardBE),
        .rd1_E        (rd1_E),
        .rd2_E        (rd2_E),
        .alu_result_M (alu_result_M),
        .result_W     (result_W),
        .md_stall     (md_stall),
        .md_done      (md_done),
        .md_result    (md_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] result;
        int          doneCycle;
        string       name;
    } exp_t;

    exp_t sbQ[$];
    int   total = 0;
    int   bad = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every md_done must match the oldest outstanding expectation, including its cycle.
    always @(negedge clk) begin
        if (!rst && md_done) begin
            if (sbQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected md_done at cycle %0d: got result 0x%08h, expected no completion", cyc, md_result);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput({e.name, " result"}, md_result, e.result);
                checkOutput({e.name, " done cycle"}, cyc, e.doneCycle);
                checkOutput({e.name, " stall in done"}, {31'b0, md_stall}, 32'd0);
            end
        end
    end

    // Called just after a rising edge; leaves the caller one cycle after the issue cycle.
    task automatic applyStimulus(input string name, input logic [2:0] f3,
                                 input logic [1:0] fa, input logic [1:0] fb,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] m, input logic [31:0] w,
                                 input int lat, input logic [31:0] expRes, input bit push);
        funct3_E     = f3;
        forwardAE    = fa;
        forwardBE    = fb;
        rd1_E        = a;
        rd2_E        = b;
        alu_result_M = m;
        result_W     = w;
        start_E      = 1'b1;
        #1;
        checkOutput({name, " issue stall"}, {31'b0, md_stall}, 32'd1);
        if (push) sbQ.push_back('{expRes, cyc + lat, name});
        @(posedge clk);
        #1;
        start_E = 1'b0;
        rd1_E   = 32'hDEAD_BEEF;
        rd2_E   = 32'hDEAD_BEEF;
        checkOutput({name, " busy stall"}, {31'b0, md_stall}, 32'd1);
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (!md_done && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({name, " reached done"}, {31'b0, md_done}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput({name, " idle after done"}, {30'b0, md_stall, md_done}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int sawDone;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset stall", {31'b0, md_stall}, 32'd0);
        checkOutput("reset done", {31'b0, md_done}, 32'd0);
        checkOutput("reset result", md_result, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus("MUL 7x6", 3'b000, 2'b00, 2'b00, 32'd7, 32'd6, 32'd0, 32'd0, 2, 32'd42, 1);
        waitDone("MUL 7x6");
        applyStimulus("MULH fwdM", 3'b001, 2'b11, 2'b00, 32'h1234_5678, 32'h8000_0000,
                      32'h8000_0000, 32'd0, 2, 32'h4000_0000, 1);
        waitDone("MULH fwdM");
        applyStimulus("MULHU max", 3'b011, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      32'd0, 32'd0, 2, 32'hFFFF_FFFE, 1);
        waitDone("MULHU max");
        applyStimulus("MULHSU -1x2", 3'b010, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd2,
                      32'd0, 32'd0, 2, 32'hFFFF_FFFF, 1);
        waitDone("MULHSU -1x2");
        applyStimulus("MUL fwd10", 3'b000, 2'b10, 2'b00, 32'd3, 32'd5, 32'd100, 32'd200, 2, 32'd15, 1);
        waitDone("MUL fwd10");

        applyStimulus("DIV -7/2 fwdW", 3'b100, 2'b00, 2'b01, 32'hFFFF_FFF9, 32'h55,
                      32'd0, 32'd2, 34, 32'hFFFF_FFFD, 1);
        waitDone("DIV -7/2 fwdW");
        applyStimulus("REM -7/2 fwdW", 3'b110, 2'b00, 2'b01, 32'hFFFF_FFF9, 32'h55,
                      32'd0, 32'd2, 34, 32'hFFFF_FFFF, 1);
        waitDone("REM -7/2 fwdW");
        applyStimulus("REMU 100/7", 3'b111, 2'b00, 2'b00, 32'd100, 32'd7, 32'd0, 32'd0, 34, 32'd2, 1);
        waitDone("REMU 100/7");
        applyStimulus("DIVU big/16", 3'b101, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'd16,
                      32'd0, 32'd0, 34, 32'h0FFF_FFFF, 1);
        waitDone("DIVU big/16");

        applyStimulus("DIVU 5/0", 3'b101, 2'b00, 2'b00, 32'd5, 32'd0, 32'd0, 32'd0, 2, 32'hFFFF_FFFF, 1);
        waitDone("DIVU 5/0");
        applyStimulus("REM ovf", 3'b110, 2'b00, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF,
                      32'd0, 32'd0, 2, 32'd0, 1);
        waitDone("REM ovf");
        applyStimulus("DIV ovf", 3'b100, 2'b00, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF,
                      32'd0, 32'd0, 2, 32'h8000_0000, 1);
        waitDone("DIV ovf");
        applyStimulus("REM by 0", 3'b110, 2'b00, 2'b00, 32'h1234, 32'd0, 32'd0, 32'd0, 2, 32'h1234, 1);
        waitDone("REM by 0");

        // Flush a divide partway through; it must vanish without a completion.
        applyStimulus("DIV flushed", 3'b100, 2'b00, 2'b00, 32'd1000, 32'd3, 32'd0, 32'd0, 34, 32'd0, 0);
        repeat (9) @(posedge clk);
        #1;
        flush_E = 1'b1;
        #1;
        checkOutput("flush stall drop", {31'b0, md_stall}, 32'd0);
        checkOutput("flush no done", {31'b0, md_done}, 32'd0);
        @(posedge clk);
        #1;
        flush_E = 1'b0;
        #1;
        checkOutput("after flush idle", {30'b0, md_stall, md_done}, 32'd0);
        sawDone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (md_done) sawDone++;
        end
        checkOutput("flush no late done", sawDone, 32'd0);
        applyStimulus("MUL after flush", 3'b000, 2'b00, 2'b00, 32'd9, 32'd9, 32'd0, 32'd0, 2, 32'd81, 1);
        waitDone("MUL after flush");

        // Asynchronous reset mid-divide, away from any clock edge.
        applyStimulus("DIV reset", 3'b100, 2'b00, 2'b00, 32'd1000, 32'd3, 32'd0, 32'd0, 34, 32'd0, 0);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async reset stall", {31'b0, md_stall}, 32'd0);
        checkOutput("async reset done", {31'b0, md_done}, 32'd0);
        checkOutput("async reset result", md_result, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post reset idle", {30'b0, md_stall, md_done}, 32'd0);

        applyStimulus("DIV 100/-3", 3'b100, 2'b00, 2'b00, 32'd100, 32'hFFFF_FFFD,
                      32'd0, 32'd0, 34, 32'hFFFF_FFDF, 1);
        waitDone("DIV 100/-3");
        applyStimulus("DIVU 1000/10", 3'b101, 2'b00, 2'b00, 32'd1000, 32'd10,
                      32'd0, 32'd0, 34, 32'd100, 1);
        waitDone("DIVU 1000/10");

        repeat (2) @(posedge clk);
        checkOutput("scoreboard drained", sbQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
